display_timings_mm: RTL and testbench
=====================================

Name: display_timings_mm

Overview:
- Runtime-switchable successor to the fixed-parameter display timing generator.
- Produces hsync, vsync, DE, frame/line strobes and signed screen coordinates for one of four built-in video modes, selected by a 2-bit input.
- Mode changes take effect only at a frame boundary.
- Sits between the display clock block and the gfx / HDMI_generator path, on the pixel clock domain.

Parameters:
- COORD_W, 16, width of the signed o_sx/o_sy outputs; must be ≥12.
- DEFAULT_MODE, 2, mode index loaded at reset (0=640x480, 1=800x600, 2=1280x720, 3=1920x1080).
- BLANK_FRAMES, 2, frames of forced DE-low after a mode change (used only with the optional feature).

Ports:
- i_pix_clk  in  1  pixel clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_mode  in  2  requested mode index, sampled every cycle
- o_hs  out  1  horizontal sync, mode polarity applied
- o_vs  out  1  vertical sync, mode polarity applied
- o_de  out  1  data enable (active area)
- o_frame  out  1  one-cycle strobe at first position of each frame
- o_line  out  1  one-cycle strobe at first position of each line
- o_sx  out  COORD_W  signed horizontal position
- o_sy  out  COORD_W  signed vertical position
- o_mode  out  2  currently active mode
- o_mode_chg  out  1  one-cycle strobe, coincident with o_frame, on the first frame of a new mode

Behaviour:
- Mode table, as H_RES/H_FP/H_SYNC/H_BP/V_RES/V_FP/V_SYNC/V_BP/H_POL/V_POL:
  - 0: 640/16/96/48/480/10/2/33/0/0
  - 1: 800/40/128/88/600/1/4/23/1/1
  - 2: 1280/110/40/220/720/5/5/20/1/1
  - 3: 1920/88/44/148/1080/4/5/36/1/1
- Derived values: H_STA = -(H_FP+H_SYNC+H_BP); V_STA likewise.
  - sx runs H_STA..H_RES-1; sy runs V_STA..V_RES-1.
  - Blanking precedes the active area.
- Sync windows:
  - hs is active when H_STA+H_FP ≤ sx < H_STA+H_FP+H_SYNC.
  - vs uses the same rule on sy.
  - Active level = POL; inactive level = !POL.
- o_de = (sx≥0 && sy≥0).
- o_line = (sx==H_STA); o_frame = (sx==H_STA && sy==V_STA).
- All outputs are registered and mutually aligned: hs/vs/de/strobes describe the same (o_sx, o_sy) shown in the same cycle.
- Each clock advances by one position.
  - sx wraps H_RES-1 → H_STA and sy increments.
  - At sx==H_RES-1 and sy==V_RES-1 (end-of-frame, EOF), the next cycle shows (H_STA, V_STA).
- Mode switch:
  - i_mode is sampled on the EOF cycle.
  - If it differs from o_mode, the new mode loads at that wrap and the next cycle shows (H_STA_new, V_STA_new) with o_frame=1, o_mode_chg=1, o_mode=new.
  - i_mode changes between EOF cycles are ignored; only the value present at EOF counts.
  - Same value at EOF: no o_mode_chg.
- Reset (i_rst_n low, asynchronous):
  - o_mode=DEFAULT_MODE, o_sx=H_STA, o_sy=V_STA of that mode.
  - o_hs/o_vs at inactive level.
  - o_de=0, o_frame=0, o_line=0, o_mode_chg=0.
  - The first o_frame after reset release occurs at the first EOF wrap.
  - Reset mid-frame discards the frame and returns to this state.
- Arithmetic: counters are COORD_W signed; comparisons are signed; no overflow is possible within the table values.

Optional Feature:
- Macro: MODE_SWITCH_BLANK_EN.
- Defined: on every o_mode_chg, a frame counter loads BLANK_FRAMES.
  - o_de is forced 0 while the counter is nonzero.
  - The counter decrements on each subsequent o_frame.
  - hs/vs/strobes are unaffected.
  - BLANK_FRAMES=0 means no forcing.
  - A new mode change while blanking reloads the counter.
  - Reset clears the counter.
- Undefined: no counter; o_de follows the active-area rule immediately.

Decomposition:
- Package display_timing_pkg holds:
  - the mode-index constants;
  - a timing record type (resolution, porches, sync widths, polarities);
  - a constant four-entry mode table.
- One sub-module, display_mode_rom:
  - combinational lookup of mode index → timing record, plus derived H_STA/V_STA and sync-window bounds;
  - keeps the counter block free of table logic.

Test Plan:
- Reset with DEFAULT_MODE=2, release → o_sx=-370, o_sy=-30, o_hs=o_vs=0, o_de=0; o_sx reaches 1279 after 1649 cycles, then wraps to -370.
- Mode 2, full frame → o_frame period 1650×750=1,237,500 cycles; o_hs high for exactly 40 cycles starting at sx=-260; o_de high for 1280×720 cycles per frame.
- Set i_mode=0 mid-frame → no change until EOF; next cycle o_sx=-160, o_sy=-45, o_mode=0, o_mode_chg=1, o_frame=1; o_hs idles 1 and pulses 0 for 96 cycles.
- Toggle i_mode 0→3→0 between EOFs, with 0 present at EOF while active is 0 → no o_mode_chg; frame period stays 800×525.
- Assert i_rst_n low at sx=100, sy=200 in mode 1 → outputs go to reset values immediately (asynchronously); o_mode=DEFAULT_MODE.
- MODE_SWITCH_BLANK_EN with BLANK_FRAMES=2, switch 2→3 → o_de stays 0 for two full 1920x1080 frames; first DE high at sx=0, sy=0 of the third frame.

Source files
------------

// File: rtl/display_timing_pkg.sv
// rtl/display_timing_pkg.sv - Video mode indices, timing record and the built-in four-entry mode table
package display_timing_pkg;

  localparam logic [1:0] MODE_640X480   = 2'd0;
  localparam logic [1:0] MODE_800X600   = 2'd1;
  localparam logic [1:0] MODE_1280X720  = 2'd2;
  localparam logic [1:0] MODE_1920X1080 = 2'd3;

  typedef struct packed {
    logic [11:0] h_res, h_fp, h_sync, h_bp;
    logic [11:0] v_res, v_fp, v_sync, v_bp;
    logic        h_pol, v_pol;
  } timing_t;

  localparam timing_t [0:3] MODE_TABLE = '{
    '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480,  12'd10, 12'd2, 12'd33, 1'b0, 1'b0},
    '{12'd800,  12'd40,  12'd128, 12'd88,  12'd600,  12'd1,  12'd4, 12'd23, 1'b1, 1'b1},
    '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd720,  12'd5,  12'd5, 12'd20, 1'b1, 1'b1},
    '{12'd1920, 12'd88,  12'd44,  12'd148, 12'd1080, 12'd4,  12'd5, 12'd36, 1'b1, 1'b1}
  };

  // Total blanking ahead of the active area; the start coordinate is its negation.
  function automatic int h_blank(timing_t t);
    return int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_blank(timing_t t);
    return int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/display_mode_rom.sv
// rtl/display_mode_rom.sv - Combinational mode lookup: start coordinates, last active coordinates and sync windows
module display_mode_rom
  import display_timing_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic [1:0]                mode,
  output logic signed [COORD_W-1:0] h_sta,
  output logic signed [COORD_W-1:0] h_last,
  output logic signed [COORD_W-1:0] hs_beg,
  output logic signed [COORD_W-1:0] hs_end,
  output logic                      h_pol,
  output logic signed [COORD_W-1:0] v_sta,
  output logic signed [COORD_W-1:0] v_last,
  output logic signed [COORD_W-1:0] vs_beg,
  output logic signed [COORD_W-1:0] vs_end,
  output logic                      v_pol
);

  timing_t t;

  assign t = MODE_TABLE[mode];

  // Sync window is [beg, end): it opens after the front porch.
  assign h_sta  = COORD_W'(-h_blank(t));
  assign h_last = COORD_W'(int'(t.h_res) - 1);
  assign hs_beg = COORD_W'(int'(t.h_fp) - h_blank(t));
  assign hs_end = COORD_W'(int'(t.h_fp) + int'(t.h_sync) - h_blank(t));
  assign h_pol  = t.h_pol;

  assign v_sta  = COORD_W'(-v_blank(t));
  assign v_last = COORD_W'(int'(t.v_res) - 1);
  assign vs_beg = COORD_W'(int'(t.v_fp) - v_blank(t));
  assign vs_end = COORD_W'(int'(t.v_fp) + int'(t.v_sync) - v_blank(t));
  assign v_pol  = t.v_pol;

endmodule

// File: rtl/display_timings_mm.sv
// rtl/display_timings_mm.sv - Runtime-switchable display timing generator; MODE_SWITCH_BLANK_EN forces DE low for BLANK_FRAMES after a mode change
module display_timings_mm
  import display_timing_pkg::*;
#(
  parameter int         COORD_W      = 16,
  parameter logic [1:0] DEFAULT_MODE = 2'd2,
  parameter int         BLANK_FRAMES = 2
) (
  input  logic                      i_pix_clk,
  input  logic                      i_rst_n,
  input  logic [1:0]                i_mode,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic                      o_de,
  output logic                      o_frame,
  output logic                      o_line,
  output logic signed [COORD_W-1:0] o_sx,
  output logic signed [COORD_W-1:0] o_sy,
  output logic [1:0]                o_mode,
  output logic                      o_mode_chg
);

  localparam timing_t DEF_T = MODE_TABLE[DEFAULT_MODE];
  localparam logic signed [COORD_W-1:0] RST_SX    = COORD_W'(-h_blank(DEF_T));
  localparam logic signed [COORD_W-1:0] RST_SY    = COORD_W'(-v_blank(DEF_T));
  localparam logic signed [COORD_W-1:0] RST_HLAST = COORD_W'(int'(DEF_T.h_res) - 1);
  localparam logic signed [COORD_W-1:0] RST_VLAST = COORD_W'(int'(DEF_T.v_res) - 1);
  localparam logic signed [COORD_W-1:0] ONE       = 1;

  logic signed [COORD_W-1:0] h_last, v_last;
  logic signed [COORD_W-1:0] nx_sx, nx_sy;
  logic signed [COORD_W-1:0] n_h_sta, n_h_last, n_hs_beg, n_hs_end;
  logic signed [COORD_W-1:0] n_v_sta, n_v_last, n_vs_beg, n_vs_end;
  logic                      n_h_pol, n_v_pol;
  logic                      hwrap, eof, mode_chg_nxt, blank_ok;
  logic [1:0]                nxt_mode;

  // Last coordinates of the running mode are held in registers so the lookup
  // only has to serve the mode that the next position belongs to.
  assign hwrap        = (o_sx == h_last);
  assign eof          = hwrap && (o_sy == v_last);
  assign nxt_mode     = eof ? i_mode : o_mode;
  assign mode_chg_nxt = eof && (i_mode != o_mode);

  display_mode_rom #(.COORD_W(COORD_W)) u_rom (
    .mode   (nxt_mode),
    .h_sta  (n_h_sta),
    .h_last (n_h_last),
    .hs_beg (n_hs_beg),
    .hs_end (n_hs_end),
    .h_pol  (n_h_pol),
    .v_sta  (n_v_sta),
    .v_last (n_v_last),
    .vs_beg (n_vs_beg),
    .vs_end (n_vs_end),
    .v_pol  (n_v_pol)
  );

  always_comb begin
    nx_sx = hwrap ? n_h_sta : o_sx + ONE;
    nx_sy = o_sy;
    if (eof)        nx_sy = n_v_sta;
    else if (hwrap) nx_sy = o_sy + ONE;
  end

`ifdef MODE_SWITCH_BLANK_EN
  localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;

  logic [BW-1:0] blank_cnt, blank_nxt;

  always_comb begin
    blank_nxt = blank_cnt;
    if (mode_chg_nxt)                  blank_nxt = BW'(BLANK_FRAMES);
    else if (eof && blank_cnt != '0)   blank_nxt = blank_cnt - BW'(1);
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) blank_cnt <= '0;
    else          blank_cnt <= blank_nxt;
  end

  assign blank_ok = (blank_nxt == '0);
`else
  logic unused_blank;
  assign unused_blank = ^BLANK_FRAMES;
  assign blank_ok     = 1'b1;
`endif

  // Every output is computed from the next position so all of them line up with o_sx/o_sy.
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sx       <= RST_SX;
      o_sy       <= RST_SY;
      o_mode     <= DEFAULT_MODE;
      h_last     <= RST_HLAST;
      v_last     <= RST_VLAST;
      o_hs       <= ~DEF_T.h_pol;
      o_vs       <= ~DEF_T.v_pol;
      o_de       <= 1'b0;
      o_frame    <= 1'b0;
      o_line     <= 1'b0;
      o_mode_chg <= 1'b0;
    end else begin
      o_sx       <= nx_sx;
      o_sy       <= nx_sy;
      o_mode     <= nxt_mode;
      h_last     <= n_h_last;
      v_last     <= n_v_last;
      o_hs       <= (nx_sx >= n_hs_beg && nx_sx < n_hs_end) ? n_h_pol : ~n_h_pol;
      o_vs       <= (nx_sy >= n_vs_beg && nx_sy < n_vs_end) ? n_v_pol : ~n_v_pol;
      o_de       <= !nx_sx[COORD_W-1] && !nx_sy[COORD_W-1] && blank_ok;
      o_frame    <= eof;
      o_line     <= hwrap;
      o_mode_chg <= mode_chg_nxt;
    end
  end

endmodule

// File: tb/tb_display_timings_mm.sv
// tb/tb_display_timings_mm.sv - Scoreboard bench: per-cycle reference model plus directed counts around a mode switch and async reset
module tb_display_timings_mm;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        i_mode;
  logic              o_hs, o_vs, o_de, o_frame, o_line, o_mode_chg;
  logic signed [15:0] o_sx, o_sy;
  logic [1:0]        o_mode;

  display_timings_mm #(.COORD_W(16), .DEFAULT_MODE(2'd0), .BLANK_FRAMES(2)) dut (
    .i_pix_clk  (clk),
    .i_rst_n    (rst_n),
    .i_mode     (i_mode),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_de       (o_de),
    .o_frame    (o_frame),
    .o_line     (o_line),
    .o_sx       (o_sx),
    .o_sy       (o_sy),
    .o_mode     (o_mode),
    .o_mode_chg (o_mode_chg)
  );

  always #5 clk = ~clk;

  localparam int H_RES  [4] = '{640, 800, 1280, 1920};
  localparam int H_FP   [4] = '{16, 40, 110, 88};
  localparam int H_SYNC [4] = '{96, 128, 40, 44};
  localparam int H_BP   [4] = '{48, 88, 220, 148};
  localparam int V_RES  [4] = '{480, 600, 720, 1080};
  localparam int V_FP   [4] = '{10, 1, 5, 4};
  localparam int V_SYNC [4] = '{2, 4, 5, 5};
  localparam int V_BP   [4] = '{33, 23, 20, 36};
  localparam bit H_POL  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit V_POL  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
`ifdef MODE_SWITCH_BLANK_EN
  localparam int MODEL_BLANK = 2;
`else
  localparam int MODEL_BLANK = 0;
`endif

  typedef struct packed {
    logic        hs, vs, de, frame, line, chg;
    logic [1:0]  mode;
    logic [15:0] sx, sy;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0, errors = 0;
  int m_sx, m_sy, m_mode, m_blank;
  bit m_chg, m_first;
  int tick_n, first_frame_tick, cnt_hs0, cnt_hs1, cnt_de, cnt_line, cnt_frame;

  function automatic int hsta_of(int m);
    return -(H_FP[m] + H_SYNC[m] + H_BP[m]);
  endfunction

  function automatic int vsta_of(int m);
    return -(V_FP[m] + V_SYNC[m] + V_BP[m]);
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int hsb, vsb;
    hsb     = hsta_of(m_mode) + H_FP[m_mode];
    vsb     = vsta_of(m_mode) + V_FP[m_mode];
    o.hs    = (m_sx >= hsb && m_sx < hsb + H_SYNC[m_mode]) ? H_POL[m_mode] : !H_POL[m_mode];
    o.vs    = (m_sy >= vsb && m_sy < vsb + V_SYNC[m_mode]) ? V_POL[m_mode] : !V_POL[m_mode];
    o.de    = (m_sx >= 0) && (m_sy >= 0) && (m_blank == 0);
    o.line  = !m_first && (m_sx == hsta_of(m_mode));
    o.frame = !m_first && (m_sx == hsta_of(m_mode)) && (m_sy == vsta_of(m_mode));
    o.chg   = m_chg;
    o.mode  = 2'(m_mode);
    o.sx    = 16'(m_sx);
    o.sy    = 16'(m_sy);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sx = hsta_of(0); m_sy = vsta_of(0);
    m_chg = 1'b0; m_first = 1'b1; m_blank = 0;
  endtask

  task automatic model_step();
    int hl, vl;
    hl = H_RES[m_mode] - 1;
    vl = V_RES[m_mode] - 1;
    m_first = 1'b0;
    m_chg   = 1'b0;
    if (m_sx == hl && m_sy == vl) begin
      m_chg  = (int'(i_mode) != m_mode);
      m_mode = int'(i_mode);
      m_sx   = hsta_of(m_mode);
      m_sy   = vsta_of(m_mode);
      if (m_chg)            m_blank = MODEL_BLANK;
      else if (m_blank > 0) m_blank--;
    end else if (m_sx == hl) begin
      m_sx = hsta_of(m_mode);
      m_sy++;
    end else begin
      m_sx++;
    end
  endtask

  task automatic check_obs(string tag);
    obs_t exp_v, got;
    exp_v = exp_q.pop_front();
    got   = {o_hs, o_vs, o_de, o_frame, o_line, o_mode_chg, o_mode, o_sx, o_sy};
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (hs,vs,de,frame,line,chg,mode,sx,sy)", tag, got, exp_v);
    end
  endtask

  task automatic chk_int(string tag, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_counts();
    cnt_hs0 = 0; cnt_hs1 = 0; cnt_de = 0; cnt_line = 0; cnt_frame = 0;
  endtask

  // One clock: model advances on the edge, DUT is sampled on the following falling edge.
  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      @(negedge clk);
      tick_n++;
      if (errors < 20) check_obs("stream");
      if (o_hs == 1'b0) cnt_hs0++; else cnt_hs1++;
      if (o_de)    cnt_de++;
      if (o_line)  cnt_line++;
      if (o_frame) begin
        cnt_frame++;
        if (first_frame_tick == 0) first_frame_tick = tick_n;
      end
    end
  endtask

  initial begin
    obs_t rst_v;
    rst_v  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'hFF60, 16'hFFD3};
    rst_n  = 1'b0;
    i_mode = 2'd0;
    tick_n = 0;
    first_frame_tick = 0;
    clear_counts();
    model_reset();

    repeat (2) @(negedge clk);
    exp_q.push_back(model_out());
    check_obs("reset_state");
    exp_q.push_back(rst_v);
    check_obs("reset_const");

    rst_n = 1'b1;
    tick(800);
    chk_int("mode0_hs_low_per_line", cnt_hs0, 96);

    // Mid-frame request changes are ignored; only the value at end-of-frame counts.
    i_mode = 2'd3;
    tick(100000);
    i_mode = 2'd1;
    tick(319200);
    chk_int("first_frame_latency", first_frame_tick, 420000);
    chk_int("frame_strobes", cnt_frame, 1);
    chk_int("line_strobes", cnt_line, 525);
    chk_int("de_per_frame", cnt_de, 640 * 480);
    chk_int("switch_sx", int'(o_sx), -256);
    chk_int("switch_sy", int'(o_sy), -28);
    chk_int("switch_mode", int'(o_mode), 1);
    chk_int("switch_chg", int'(o_mode_chg), 1);
    chk_int("switch_frame", int'(o_frame), 1);

    clear_counts();
    i_mode = 2'd2;
    tick(1056);
    chk_int("mode1_hs_high_per_line", cnt_hs1, 128);
    chk_int("mode1_line_strobes", cnt_line, 1);
    chk_int("mode1_no_chg_midframe", int'(o_mode), 1);
    tick(2000);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(rst_v);
    check_obs("async_reset");
    @(negedge clk);
    exp_q.push_back(model_out());
    check_obs("reset_hold");

    i_mode = 2'd0;
    rst_n  = 1'b1;
    clear_counts();
    tick(1600);
    chk_int("post_reset_lines", cnt_line, 2);
    chk_int("post_reset_hs_low", cnt_hs0, 192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
